// File: rtl/stopwatch_ctrl.sv
// Stop-watch control front end: debounces the three buttons, runs the idle/run/pause
// FSM and generates the count tick, clear pulse and lap-hold flag for the BCD cascade.
module stopwatch_ctrl #(
    parameter logic [15:0] CLK_DIV  = 16'd50000,
    parameter logic [15:0] DEBOUNCE = 16'd20000
) (
    input  logic       clk,
    input  logic       reset,
    input  logic       btn_ss,
    input  logic       btn_clr,
    input  logic       btn_lap,
    output logic       ci,
    output logic       clr,
    output logic       hold,
    output logic [1:0] state
);

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        RUN   = 2'b01,
        PAUSE = 2'b10
    } state_t;

    localparam int NUM_BTN = 3;
    localparam int BTN_SS  = 0;
    localparam int BTN_CLR = 1;
    localparam int BTN_LAP = 2;

    logic [NUM_BTN-1:0] btn_raw;
    logic [NUM_BTN-1:0] press;

    assign btn_raw = {btn_lap, btn_clr, btn_ss};

    genvar gi;
    generate
        for (gi = 0; gi < NUM_BTN; gi = gi + 1) begin : g_btn
            logic        sync1_q, sync1_d;
            logic        sync2_q, sync2_d;
            logic        deb_q, deb_d;
            logic        press_q, press_d;
            logic [15:0] cnt_q, cnt_d;

            // Counter measures how long the synchronised level has disagreed with the accepted one.
            always_comb begin
                sync1_d = btn_raw[gi];
                sync2_d = sync1_q;
                cnt_d   = cnt_q;
                deb_d   = deb_q;
                if (sync2_q == deb_q) begin
                    cnt_d = '0;
                end else if (cnt_q + 16'd1 == DEBOUNCE) begin
                    cnt_d = '0;
                    deb_d = sync2_q;
                end else begin
                    cnt_d = cnt_q + 16'd1;
                end
                press_d = deb_d & ~deb_q;
            end

            always_ff @(posedge clk) begin
                if (reset) begin
                    sync1_q <= 1'b0;
                    sync2_q <= 1'b0;
                    deb_q   <= 1'b0;
                    press_q <= 1'b0;
                    cnt_q   <= '0;
                end else begin
                    sync1_q <= sync1_d;
                    sync2_q <= sync2_d;
                    deb_q   <= deb_d;
                    press_q <= press_d;
                    cnt_q   <= cnt_d;
                end
            end

            assign press[gi] = press_q;
        end
    endgenerate

    logic ev_ss, ev_clr, ev_lap;

    assign ev_ss  = press[BTN_SS];
    assign ev_clr = press[BTN_CLR];
    assign ev_lap = press[BTN_LAP];

    state_t      state_q, state_d;
    logic        hold_q, hold_d;
    logic        clr_q, clr_d;
    logic        ci_q, ci_d;
    logic [15:0] presc_q, presc_d;

    always_comb begin
        state_d = state_q;
        hold_d  = hold_q;
        clr_d   = 1'b0;
        case (state_q)
            IDLE: begin
                hold_d = 1'b0;
                if (ev_clr) begin
                    clr_d = 1'b1;
                end else if (ev_ss) begin
                    state_d = RUN;
                end
            end
            RUN: begin
                if (ev_ss) begin
                    state_d = PAUSE;
                end
                if (ev_lap) begin
                    hold_d = ~hold_q;
                end
            end
            PAUSE: begin
                // Clear takes precedence over a simultaneous resume.
                if (ev_clr) begin
                    state_d = IDLE;
                    clr_d   = 1'b1;
                    hold_d  = 1'b0;
                end else begin
                    if (ev_ss) begin
                        state_d = RUN;
                    end
                    if (ev_lap) begin
                        hold_d = 1'b0;
                    end
                end
            end
            default: begin
                state_d = IDLE;
                hold_d  = 1'b0;
            end
        endcase
    end

    // A wrap that coincides with leaving RUN is swallowed so ci only ever appears while running.
    always_comb begin
        presc_d = presc_q;
        ci_d    = 1'b0;
        if (state_q == IDLE || clr_d) begin
            presc_d = '0;
        end else if (state_q == RUN) begin
            if (presc_q == CLK_DIV - 16'd1) begin
                presc_d = '0;
                ci_d    = (state_d == RUN);
            end else begin
                presc_d = presc_q + 16'd1;
            end
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q <= IDLE;
            hold_q  <= 1'b0;
            clr_q   <= 1'b1;
            ci_q    <= 1'b0;
            presc_q <= '0;
        end else begin
            state_q <= state_d;
            hold_q  <= hold_d;
            clr_q   <= clr_d;
            ci_q    <= ci_d;
            presc_q <= presc_d;
        end
    end

    assign ci    = ci_q;
    assign clr   = clr_q;
    assign hold  = hold_q;
    assign state = state_q;

endmodule

// File: tb/tb_stopwatch_ctrl.sv
// Directed bench for stopwatch_ctrl with CLK_DIV=4 and DEBOUNCE=3; raw-to-state latency is 6 cycles.
module tb_stopwatch_ctrl;

    localparam logic [15:0] CLK_DIV  = 16'd4;
    localparam logic [15:0] DEBOUNCE = 16'd3;
    localparam logic [1:0]  S_IDLE   = 2'b00;
    localparam logic [1:0]  S_RUN    = 2'b01;
    localparam logic [1:0]  S_PAUSE  = 2'b10;

    logic       clk     = 1'b0;
    logic       reset   = 1'b0;
    logic       btn_ss  = 1'b0;
    logic       btn_clr = 1'b0;
    logic       btn_lap = 1'b0;
    logic       ci;
    logic       clr;
    logic       hold;
    logic [1:0] state;

    int n_checks = 0;
    int n_fail   = 0;

    stopwatch_ctrl #(
        .CLK_DIV (CLK_DIV),
        .DEBOUNCE(DEBOUNCE)
    ) dut (
        .clk    (clk),
        .reset  (reset),
        .btn_ss (btn_ss),
        .btn_clr(btn_clr),
        .btn_lap(btn_lap),
        .ci     (ci),
        .clr    (clr),
        .hold   (hold),
        .state  (state)
    );

    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    // ci must never appear outside RUN or together with clr
    always @(negedge clk) begin
        if (ci === 1'b1) begin
            n_checks++;
            if (clr !== 1'b0 || state !== S_RUN) begin
                n_fail++;
                $display("FAIL ci_only_in_run: ci=%b clr=%b state=%b, required clr=0 state=01", ci, clr, state);
            end
        end
    end

    task automatic test_reset();
        reset = 1'b1;
        step(1);
        n_checks++; if (clr !== 1'b1) begin n_fail++; $display("FAIL reset_clr_c1: got %b expected 1", clr); end
        step(1);
        n_checks++; if (clr !== 1'b1) begin n_fail++; $display("FAIL reset_clr_c2: got %b expected 1", clr); end
        n_checks++; if (state !== S_IDLE) begin n_fail++; $display("FAIL reset_state: got %b expected 00", state); end
        n_checks++; if (ci !== 1'b0) begin n_fail++; $display("FAIL reset_ci: got %b expected 0", ci); end
        n_checks++; if (hold !== 1'b0) begin n_fail++; $display("FAIL reset_hold: got %b expected 0", hold); end
        reset = 1'b0;
        step(1);
        n_checks++; if (clr !== 1'b0) begin n_fail++; $display("FAIL post_reset_clr: got %b expected 0", clr); end
        n_checks++; if (state !== S_IDLE) begin n_fail++; $display("FAIL post_reset_state: got %b expected 00", state); end
        n_checks++; if (ci !== 1'b0) begin n_fail++; $display("FAIL post_reset_ci: got %b expected 0", ci); end
        n_checks++; if (hold !== 1'b0) begin n_fail++; $display("FAIL post_reset_hold: got %b expected 0", hold); end
        $display("test_reset done: clr=%b state=%b", clr, state);
    endtask

    task automatic test_start_tick();
        int   n;
        logic exp_ci;
        btn_ss = 1'b1;
        n = 0;
        while (state !== S_RUN && n < 20) begin step(1); n++; end
        n_checks++; if (n != 6) begin n_fail++; $display("FAIL start_latency: got %0d cycles expected 6", n); end
        for (int k = 1; k <= 20; k++) begin
            step(1);
            exp_ci = (k % 4 == 0);
            n_checks++; if (ci !== exp_ci) begin n_fail++; $display("FAIL start_tick k=%0d: got ci=%b expected %b", k, ci, exp_ci); end
            n_checks++; if (state !== S_RUN) begin n_fail++; $display("FAIL start_stay_run k=%0d: got %b expected 01", k, state); end
            if (k == 4) btn_ss = 1'b0;
        end
        $display("test_start_tick done: latency=%0d state=%b", n, state);
    endtask

    task automatic test_pause_resume();
        int         n;
        logic       exp_ci;
        logic [1:0] exp_state;
        // entered on a ci cycle, so pause lands with prescaler at 2
        btn_ss = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            exp_state = (k < 6) ? S_RUN : S_PAUSE;
            exp_ci    = (k == 4);
            n_checks++; if (state !== exp_state) begin n_fail++; $display("FAIL pause_state k=%0d: got %b expected %b", k, state, exp_state); end
            n_checks++; if (ci !== exp_ci) begin n_fail++; $display("FAIL pause_ci k=%0d: got %b expected %b", k, ci, exp_ci); end
        end
        btn_ss = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            n_checks++; if (state !== S_PAUSE) begin n_fail++; $display("FAIL paused_state k=%0d: got %b expected 10", k, state); end
            n_checks++; if (ci !== 1'b0) begin n_fail++; $display("FAIL paused_ci k=%0d: got %b expected 0", k, ci); end
        end
        n_checks++; if (dut.presc_q !== 16'd2) begin n_fail++; $display("FAIL paused_prescaler: got %0d expected 2", dut.presc_q); end
        btn_ss = 1'b1;
        n = 0;
        while (state !== S_RUN && n < 20) begin step(1); n++; end
        n_checks++; if (n != 6) begin n_fail++; $display("FAIL resume_latency: got %0d expected 6", n); end
        for (int k = 1; k <= 10; k++) begin
            step(1);
            exp_ci = (k == 2 || k == 6 || k == 10);
            n_checks++; if (ci !== exp_ci) begin n_fail++; $display("FAIL resume_tick k=%0d: got %b expected %b", k, ci, exp_ci); end
            if (k == 2) btn_ss = 1'b0;
        end
        $display("test_pause_resume done: state=%b", state);
    endtask

    task automatic test_clear();
        int   n;
        logic exp_ci;
        // clear while running is ignored
        btn_clr = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            exp_ci = (k % 4 == 0);
            n_checks++; if (clr !== 1'b0) begin n_fail++; $display("FAIL run_clr_ignored k=%0d: got %b expected 0", k, clr); end
            n_checks++; if (state !== S_RUN) begin n_fail++; $display("FAIL run_clr_state k=%0d: got %b expected 01", k, state); end
            n_checks++; if (ci !== exp_ci) begin n_fail++; $display("FAIL run_clr_ci k=%0d: got %b expected %b", k, ci, exp_ci); end
            if (k == 8) btn_clr = 1'b0;
        end
        btn_ss = 1'b1;
        step(6);
        n_checks++; if (state !== S_PAUSE) begin n_fail++; $display("FAIL clear_setup_pause: got %b expected 10", state); end
        btn_ss = 1'b0;
        step(8);
        // clear from pause
        btn_clr = 1'b1;
        n = 0;
        while (clr !== 1'b1 && n < 20) begin step(1); n++; end
        n_checks++; if (n != 6) begin n_fail++; $display("FAIL pause_clr_latency: got %0d expected 6", n); end
        n_checks++; if (state !== S_IDLE) begin n_fail++; $display("FAIL pause_clr_state: got %b expected 00", state); end
        n_checks++; if (hold !== 1'b0) begin n_fail++; $display("FAIL pause_clr_hold: got %b expected 0", hold); end
        step(1);
        n_checks++; if (clr !== 1'b0) begin n_fail++; $display("FAIL pause_clr_width: got %b expected 0", clr); end
        btn_clr = 1'b0;
        step(8);
        // clear from idle
        btn_clr = 1'b1;
        n = 0;
        while (clr !== 1'b1 && n < 20) begin step(1); n++; end
        n_checks++; if (n != 6) begin n_fail++; $display("FAIL idle_clr_latency: got %0d expected 6", n); end
        n_checks++; if (state !== S_IDLE) begin n_fail++; $display("FAIL idle_clr_state: got %b expected 00", state); end
        step(1);
        n_checks++; if (clr !== 1'b0) begin n_fail++; $display("FAIL idle_clr_width: got %b expected 0", clr); end
        btn_clr = 1'b0;
        step(8);
        n_checks++; if (state !== S_IDLE) begin n_fail++; $display("FAIL idle_after_clr: got %b expected 00", state); end
        $display("test_clear done: state=%b", state);
    endtask

    task automatic test_simultaneous();
        btn_ss = 1'b1;
        step(6);
        n_checks++; if (state !== S_RUN) begin n_fail++; $display("FAIL simul_setup_run: got %b expected 01", state); end
        btn_ss = 1'b0;
        step(8);
        btn_ss = 1'b1;
        step(6);
        n_checks++; if (state !== S_PAUSE) begin n_fail++; $display("FAIL simul_setup_pause: got %b expected 10", state); end
        btn_ss = 1'b0;
        step(8);
        btn_ss  = 1'b1;
        btn_clr = 1'b1;
        step(5);
        n_checks++; if (state !== S_PAUSE) begin n_fail++; $display("FAIL simul_before: got %b expected 10", state); end
        n_checks++; if (clr !== 1'b0) begin n_fail++; $display("FAIL simul_clr_early: got %b expected 0", clr); end
        step(1);
        n_checks++; if (state !== S_IDLE) begin n_fail++; $display("FAIL simul_state: got %b expected 00", state); end
        n_checks++; if (clr !== 1'b1) begin n_fail++; $display("FAIL simul_clr: got %b expected 1", clr); end
        btn_ss  = 1'b0;
        btn_clr = 1'b0;
        step(1);
        n_checks++; if (clr !== 1'b0) begin n_fail++; $display("FAIL simul_clr_width: got %b expected 0", clr); end
        step(8);
        n_checks++; if (state !== S_IDLE) begin n_fail++; $display("FAIL simul_after: got %b expected 00", state); end
        $display("test_simultaneous done: state=%b", state);
    endtask

    task automatic test_lap();
        int         n;
        logic       exp_ci;
        logic       exp_hold;
        logic [1:0] exp_state;
        btn_ss = 1'b1;
        n = 0;
        while (state !== S_RUN && n < 20) begin step(1); n++; end
        n_checks++; if (n != 6) begin n_fail++; $display("FAIL lap_setup_latency: got %0d expected 6", n); end
        for (int k = 1; k <= 12; k++) begin
            step(1);
            if (k == 4) btn_ss = 1'b0;
        end
        // first lap: hold rises, ticks continue
        btn_lap = 1'b1;
        for (int k = 1; k <= 24; k++) begin
            step(1);
            exp_ci   = (k % 4 == 0);
            exp_hold = (k >= 6);
            n_checks++; if (ci !== exp_ci) begin n_fail++; $display("FAIL lap1_ci k=%0d: got %b expected %b", k, ci, exp_ci); end
            n_checks++; if (hold !== exp_hold) begin n_fail++; $display("FAIL lap1_hold k=%0d: got %b expected %b", k, hold, exp_hold); end
            if (k == 8) btn_lap = 1'b0;
        end
        // second lap: hold falls
        btn_lap = 1'b1;
        for (int k = 1; k <= 16; k++) begin
            step(1);
            exp_ci   = (k % 4 == 0);
            exp_hold = (k < 6);
            n_checks++; if (ci !== exp_ci) begin n_fail++; $display("FAIL lap2_ci k=%0d: got %b expected %b", k, ci, exp_ci); end
            n_checks++; if (hold !== exp_hold) begin n_fail++; $display("FAIL lap2_hold k=%0d: got %b expected %b", k, hold, exp_hold); end
            if (k == 8) btn_lap = 1'b0;
        end
        // lap then start/stop one cycle later
        btn_lap = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            step(1);
            exp_ci    = (k == 4);
            exp_hold  = (k >= 6);
            exp_state = (k < 7) ? S_RUN : S_PAUSE;
            n_checks++; if (ci !== exp_ci) begin n_fail++; $display("FAIL lapss_ci k=%0d: got %b expected %b", k, ci, exp_ci); end
            n_checks++; if (hold !== exp_hold) begin n_fail++; $display("FAIL lapss_hold k=%0d: got %b expected %b", k, hold, exp_hold); end
            n_checks++; if (state !== exp_state) begin n_fail++; $display("FAIL lapss_state k=%0d: got %b expected %b", k, state, exp_state); end
            if (k == 1) btn_ss = 1'b1;
        end
        btn_lap = 1'b0;
        btn_ss  = 1'b0;
        step(8);
        n_checks++; if (hold !== 1'b1) begin n_fail++; $display("FAIL pause_hold_kept: got %b expected 1", hold); end
        // lap in pause clears hold
        btn_lap = 1'b1;
        for (int k = 1; k <= 6; k++) begin
            step(1);
            exp_hold = (k < 6);
            n_checks++; if (hold !== exp_hold) begin n_fail++; $display("FAIL pause_lap_hold k=%0d: got %b expected %b", k, hold, exp_hold); end
            n_checks++; if (state !== S_PAUSE) begin n_fail++; $display("FAIL pause_lap_state k=%0d: got %b expected 10", k, state); end
        end
        btn_lap = 1'b0;
        step(8);
        btn_clr = 1'b1;
        step(6);
        n_checks++; if (state !== S_IDLE) begin n_fail++; $display("FAIL lap_exit_idle: got %b expected 00", state); end
        btn_clr = 1'b0;
        step(8);
        $display("test_lap done: state=%b hold=%b", state, hold);
    endtask

    task automatic test_glitch();
        btn_ss = 1'b1;
        step(2);
        btn_ss = 1'b0;
        for (int k = 1; k <= 10; k++) begin
            step(1);
            n_checks++; if (state !== S_IDLE) begin n_fail++; $display("FAIL glitch_state k=%0d: got %b expected 00", k, state); end
        end
        $display("test_glitch done: state=%b", state);
    endtask

    task automatic test_midrun_reset();
        int   n;
        logic exp_ci;
        btn_ss = 1'b1;
        n = 0;
        while (state !== S_RUN && n < 20) begin step(1); n++; end
        n_checks++; if (n != 6) begin n_fail++; $display("FAIL mrr_setup_latency: got %0d expected 6", n); end
        for (int k = 1; k <= 12; k++) begin
            step(1);
            if (k == 4) btn_ss = 1'b0;
        end
        step(3);
        n_checks++; if (dut.presc_q !== 16'd3) begin n_fail++; $display("FAIL mrr_prescaler: got %0d expected 3", dut.presc_q); end
        reset = 1'b1;
        step(1);
        n_checks++; if (ci !== 1'b0) begin n_fail++; $display("FAIL mrr_ci: got %b expected 0", ci); end
        n_checks++; if (state !== S_IDLE) begin n_fail++; $display("FAIL mrr_state: got %b expected 00", state); end
        n_checks++; if (clr !== 1'b1) begin n_fail++; $display("FAIL mrr_clr: got %b expected 1", clr); end
        n_checks++; if (hold !== 1'b0) begin n_fail++; $display("FAIL mrr_hold: got %b expected 0", hold); end
        reset = 1'b0;
        step(1);
        n_checks++; if (clr !== 1'b0) begin n_fail++; $display("FAIL mrr_clr_release: got %b expected 0", clr); end
        n_checks++; if (ci !== 1'b0) begin n_fail++; $display("FAIL mrr_ci_release: got %b expected 0", ci); end
        btn_ss = 1'b1;
        n = 0;
        while (state !== S_RUN && n < 20) begin step(1); n++; end
        n_checks++; if (n != 6) begin n_fail++; $display("FAIL mrr_restart_latency: got %0d expected 6", n); end
        for (int k = 1; k <= 4; k++) begin
            step(1);
            exp_ci = (k == 4);
            n_checks++; if (ci !== exp_ci) begin n_fail++; $display("FAIL mrr_first_tick k=%0d: got %b expected %b", k, ci, exp_ci); end
        end
        btn_ss = 1'b0;
        step(8);
        $display("test_midrun_reset done: state=%b", state);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached before completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        test_reset();
        test_start_tick();
        test_pause_resume();
        test_clear();
        test_simultaneous();
        test_lap();
        test_glitch();
        test_midrun_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
